// File: rtl/udp_payload_extractor.sv
// udp_payload_extractor
// Validates and strips a fixed 42-byte Eth/IPv4/UDP header from a 64-bit AXIS
// frame stream, then forwards the UDP payload re-aligned to lane 0. Frames with
// a bad header or an empty payload are dropped whole.
// Lane 0 (first wire byte) is tdata[63:56]; byteEnable bit 7 maps to lane 0.
module udp_payload_extractor #(
   parameter int unsigned WIDTH    = 64,
   parameter logic [15:0] UDP_PORT = 16'h4E20,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     slave_tdata,
   input  logic [WIDTH/8-1:0]   slave_byteEnable,
   input  logic                 slave_tvalid,
   input  logic                 slave_tlast,
   output logic                 slave_tready,
   output logic [WIDTH-1:0]     master_tdata,
   output logic [WIDTH/8-1:0]   master_byteEnable,
   output logic                 master_tvalid,
   output logic                 master_tlast,
   input  logic                 master_tready,
   output logic [CNT_W-1:0]     frames_ok,
   output logic [CNT_W-1:0]     frames_dropped
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {
      S_HDR,
      S_DROP,
      S_PAY,
      S_FLUSH
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic                hdr_ok_q, hdr_ok_d;
   logic                first_q, first_d;
   logic [47:0]         res_q, res_d;
   logic [5:0]          res_be_q, res_be_d;
   logic                mv_q, mv_d;
   logic [WIDTH-1:0]    md_q, md_d;
   logic [WIDTH/8-1:0]  mbe_q, mbe_d;
   logic                ml_q, ml_d;
   logic [CNT_W-1:0]    ok_q, ok_d;
   logic [CNT_W-1:0]    drop_q, drop_d;
   logic                alive_q;
   logic                accept;
   logic                out_hs;

   // Holds slave_tready low during reset and the first cycle after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive_q <= 1'b0;
      else        alive_q <= 1'b1;
   end

   // State, header tracking, residue, output register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_HDR;
         idx_q    <= '0;
         hdr_ok_q <= 1'b0;
         first_q  <= 1'b0;
         res_q    <= '0;
         res_be_q <= '0;
         mv_q     <= 1'b0;
         md_q     <= '0;
         mbe_q    <= '0;
         ml_q     <= 1'b0;
         ok_q     <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         hdr_ok_q <= hdr_ok_d;
         first_q  <= first_d;
         res_q    <= res_d;
         res_be_q <= res_be_d;
         mv_q     <= mv_d;
         md_q     <= md_d;
         mbe_q    <= mbe_d;
         ml_q     <= ml_d;
         ok_q     <= ok_d;
         drop_q   <= drop_d;
      end
   end

   // Next-state, handshake and output-register load logic
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      hdr_ok_d     = hdr_ok_q;
      first_d      = first_q;
      res_d        = res_q;
      res_be_d     = res_be_q;
      mv_d         = mv_q;
      md_d         = md_q;
      mbe_d        = mbe_q;
      ml_d         = ml_q;
      ok_d         = ok_q;
      drop_d       = drop_q;
      slave_tready = 1'b0;

      // Output register drains independently of the parser state
      out_hs = mv_q && master_tready;
      if (out_hs) begin
         mv_d = 1'b0;
         if (ml_q) ok_d = ok_q + CNT_ONE;
      end

      case (state_q)
         S_HDR:   slave_tready = alive_q;
         S_DROP:  slave_tready = alive_q;
         S_PAY:   slave_tready = alive_q && (!mv_q || master_tready);
         default: slave_tready = 1'b0;
      endcase
      accept = slave_tvalid && slave_tready;

      case (state_q)
         S_HDR: begin
            if (accept) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd1)
                  hdr_ok_d = (slave_tdata[31:16] == 16'h0800) && (slave_tdata[15:8] == 8'h45);
               else if (idx_q == 3'd2)
                  hdr_ok_d = hdr_ok_q && (slave_tdata[7:0] == 8'h11);

               if (slave_tlast) begin
                  idx_d  = '0;
                  drop_d = drop_q + CNT_ONE;
               end else if (idx_q == 3'd4) begin
                  idx_d   = '0;
                  first_d = 1'b1;
                  if (hdr_ok_q && (slave_tdata[31:16] == UDP_PORT)) state_d = S_PAY;
                  else                                             state_d = S_DROP;
               end
            end
         end

         S_DROP: begin
            if (accept && slave_tlast) begin
               drop_d  = drop_q + CNT_ONE;
               state_d = S_HDR;
            end
         end

         S_PAY: begin
            if (accept) begin
               res_d    = slave_tdata[47:0];
               res_be_d = slave_byteEnable[5:0];
               if (first_q) begin
                  // Beat 5 only primes the residue; a last beat here flushes it directly
                  first_d = 1'b0;
                  if (slave_tlast) begin
                     state_d = S_HDR;
                     if (!slave_byteEnable[5]) begin
                        drop_d = drop_q + CNT_ONE;
                     end else begin
                        mv_d  = 1'b1;
                        md_d  = {slave_tdata[47:0], 16'h0000};
                        mbe_d = {slave_byteEnable[5:0], 2'b00};
                        ml_d  = 1'b1;
                     end
                  end
               end else begin
                  mv_d  = 1'b1;
                  md_d  = {res_q, slave_tdata[63:48]};
                  mbe_d = {6'b111111, slave_byteEnable[7:6]};
                  ml_d  = slave_tlast && !slave_byteEnable[5];
                  if (slave_tlast) state_d = slave_byteEnable[5] ? S_FLUSH : S_HDR;
               end
            end
         end

         S_FLUSH: begin
            if (!mv_q || master_tready) begin
               mv_d    = 1'b1;
               md_d    = {res_q, 16'h0000};
               mbe_d   = {res_be_q, 2'b00};
               ml_d    = 1'b1;
               state_d = S_HDR;
            end
         end

         default: state_d = S_HDR;
      endcase
   end

   assign master_tvalid     = mv_q;
   assign master_tdata      = md_q;
   assign master_byteEnable = mbe_q;
   assign master_tlast      = ml_q;
   assign frames_ok         = ok_q;
   assign frames_dropped    = drop_q;

endmodule

// File: tb/tb_udp_payload_extractor.sv
// Scoreboard bench for udp_payload_extractor: frames are built as byte arrays,
// the reference model derives the expected payload beats directly from the
// bytes, and a monitor compares every output handshake against the queue.
module tb_udp_payload_extractor;

   localparam logic [15:0] PORT = 16'h4E20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] slave_tdata = '0;
   logic [7:0]  slave_byteEnable = '0;
   logic        slave_tvalid = 1'b0;
   logic        slave_tlast = 1'b0;
   logic        slave_tready;
   logic [63:0] master_tdata;
   logic [7:0]  master_byteEnable;
   logic        master_tvalid;
   logic        master_tlast;
   logic        master_tready = 1'b1;
   logic [31:0] frames_ok;
   logic [31:0] frames_dropped;

   udp_payload_extractor #(
      .WIDTH(64),
      .UDP_PORT(PORT),
      .CNT_W(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .slave_tdata(slave_tdata),
      .slave_byteEnable(slave_byteEnable),
      .slave_tvalid(slave_tvalid),
      .slave_tlast(slave_tlast),
      .slave_tready(slave_tready),
      .master_tdata(master_tdata),
      .master_byteEnable(master_byteEnable),
      .master_tvalid(master_tvalid),
      .master_tlast(master_tlast),
      .master_tready(master_tready),
      .frames_ok(frames_ok),
      .frames_dropped(frames_dropped)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  be;
      logic        last;
   } beat_t;

   beat_t        exp_q[$];
   byte unsigned frm[$];
   int unsigned  n_checks = 0;
   int unsigned  n_pass = 0;
   int unsigned  exp_ok = 0;
   int unsigned  exp_drop = 0;
   int unsigned  rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready
   bit           gaps = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   // Downstream ready, changed just after each rising edge
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       master_tready = 1'b1;
         1:       master_tready = 1'($urandom_range(0, 1));
         default: master_tready = 1'b0;
      endcase
   end

   // Monitor: samples mid-cycle, pops the scoreboard on every output handshake
   initial begin
      beat_t exp_b;
      beat_t act_b;
      beat_t held;
      bit    stalled;
      stalled = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         act_b = '{d: master_tdata, be: master_byteEnable, last: master_tlast};
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled)
               chk(master_tvalid && (act_b == held), "hold_while_stalled",
                   {23'd0, master_tvalid, act_b}, {23'd0, 1'b1, held});
            if (master_tvalid && master_tready) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_beat", {23'd0, act_b}, '0);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk(act_b == exp_b, "payload_beat", {23'd0, act_b}, {23'd0, exp_b});
               end
            end
            stalled = master_tvalid && !master_tready;
            held = act_b;
         end
      end
   end

   // Build a frame of len random bytes with the given header fields
   task automatic mk_frame(input int unsigned len, input logic [15:0] et, input logic [7:0] vih,
                           input logic [7:0] pr, input logic [15:0] dp);
      frm.delete();
      for (int unsigned i = 0; i < len; i++) frm.push_back(byte'($urandom_range(0, 255)));
      if (len > 12) frm[12] = et[15:8];
      if (len > 13) frm[13] = et[7:0];
      if (len > 14) frm[14] = vih;
      if (len > 23) frm[23] = pr;
      if (len > 36) frm[36] = dp[15:8];
      if (len > 37) frm[37] = dp[7:0];
   endtask

   // Reference model: payload = bytes 42..end, packed 8 per beat, if header good and non-empty
   task automatic model_frame();
      int unsigned len;
      bit          good;
      beat_t       b;
      len  = frm.size();
      good = (len >= 43) && (frm[12] == 8'h08) && (frm[13] == 8'h00) && (frm[14] == 8'h45) &&
             (frm[23] == 8'h11) && ({frm[36], frm[37]} == PORT);
      if (!good) begin
         exp_drop++;
      end else begin
         exp_ok++;
         for (int unsigned off = 42; off < len; off += 8) begin
            b = '0;
            for (int unsigned l = 0; l < 8; l++) begin
               if (off + l < len) begin
                  b.d[63 - 8*l -: 8] = frm[off + l];
                  b.be[7 - l] = 1'b1;
               end
            end
            b.last = (off + 8 >= len);
            exp_q.push_back(b);
         end
      end
   endtask

   // Drive up to max_beats beats of frm; entered and left just after a rising edge
   task automatic send_frame(input int unsigned max_beats);
      int unsigned nb;
      int unsigned t;
      nb = (frm.size() + 7) / 8;
      for (int unsigned b = 0; b < nb && b < max_beats; b++) begin
         if (gaps && $urandom_range(0, 7) == 0) begin
            slave_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         slave_tdata = '0;
         slave_byteEnable = '0;
         for (int unsigned l = 0; l < 8; l++) begin
            if (8*b + l < frm.size()) begin
               slave_tdata[63 - 8*l -: 8] = frm[8*b + l];
               slave_byteEnable[7 - l] = 1'b1;
            end
         end
         slave_tlast = (b == nb - 1);
         slave_tvalid = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (slave_tready) break;
            t++;
            if (t > 5000) break;
         end
         if (t > 5000) begin
            chk(1'b0, "slave_tready_timeout", 96'(t), 96'd0);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      slave_tvalid = 1'b0;
      slave_tlast = 1'b0;
   endtask

   task automatic run_frame(input int unsigned len, input logic [15:0] et, input logic [7:0] vih,
                            input logic [7:0] pr, input logic [15:0] dp);
      mk_frame(len, et, vih, pr, dp);
      model_frame();
      send_frame(1000);
   endtask

   task automatic drain_and_check(input string name);
      int unsigned t;
      t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      chk(exp_q.size() == 0, "drain", 96'(exp_q.size()), 96'd0);
      repeat (3) begin @(posedge clk); #1; end
      chk(frames_ok == exp_ok, {name, "_frames_ok"}, 96'(frames_ok), 96'(exp_ok));
      chk(frames_dropped == exp_drop, {name, "_frames_dropped"}, 96'(frames_dropped), 96'(exp_drop));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      chk(!slave_tready && !master_tvalid && !master_tlast, "reset_ctrl",
          {slave_tready, master_tvalid, master_tlast}, '0);
      chk(master_tdata == '0 && master_byteEnable == '0, "reset_data",
          {master_tdata, master_byteEnable}, '0);
      chk(frames_ok == '0 && frames_dropped == '0, "reset_counters",
          {frames_ok, frames_dropped}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Good frames: two full beats, one full beat, full + single-lane flush
      rdy_mode = 0;
      run_frame(58, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(50, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(51, 16'h0800, 8'h45, 8'h11, PORT);
      drain_and_check("good");

      // Header rejects, then a good frame back to back
      run_frame(80, 16'h0800, 8'h45, 8'h11, 16'h1234);
      run_frame(80, 16'h86DD, 8'h45, 8'h11, PORT);
      run_frame(80, 16'h0800, 8'h45, 8'h06, PORT);
      run_frame(77, 16'h0800, 8'h45, 8'h11, PORT);
      drain_and_check("reject");

      // Runts and short payloads
      run_frame(30, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(40, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(42, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(41, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(45, 16'h0800, 8'h45, 8'h11, PORT);
      run_frame(43, 16'h0800, 8'h45, 8'h11, PORT);
      drain_and_check("runt");

      // Reset mid-payload with an output beat held
      rdy_mode = 2;
      mk_frame(200, 16'h0800, 8'h45, 8'h11, PORT);
      send_frame(7);
      chk(master_tvalid == 1'b1, "pre_reset_tvalid", 96'(master_tvalid), 96'd1);
      rst_n = 1'b0;
      #1;
      chk(!slave_tready && !master_tvalid && !master_tlast && master_tdata == '0 &&
          master_byteEnable == '0, "midframe_reset_outputs",
          {slave_tready, master_tvalid, master_tlast, master_tdata, master_byteEnable}, '0);
      chk(frames_ok == '0 && frames_dropped == '0, "midframe_reset_counters",
          {frames_ok, frames_dropped}, '0);
      exp_q.delete();
      exp_ok = 0;
      exp_drop = 0;
      rdy_mode = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(99, 16'h0800, 8'h45, 8'h11, PORT);
      drain_and_check("post_reset");

      // Random backpressure over many good frames
      rdy_mode = 1;
      gaps = 1'b1;
      for (int unsigned i = 0; i < 200; i++)
         run_frame($urandom_range(43, 1500), 16'h0800, 8'h45, 8'h11, PORT);
      drain_and_check("random");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
